// File: rtl/state_button.sv
// state_button: top-level control FSM for the LED-matrix music demo.
// Conditions three raw push-buttons (synchronise, debounce, rising-edge
// detect) and sequences START -> MENU -> PLAY -> FINISH -> MENU.
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   finish        song-finished level from the player (already clk-synchronous)
//   red_button    raw async button: START->MENU, MENU song decrement
//   blue_button   raw async button: MENU song increment, PLAY abort
//   yellow_button raw async button: MENU->PLAY, FINISH->MENU
//   song_confirm  registered selected song index
//   state         registered FSM state (START=00 MENU=01 PLAY=10 FINISH=11)
module state_button #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1,
   parameter int unsigned NUM_SONGS       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       finish,
   input  logic       red_button,
   input  logic       blue_button,
   input  logic       yellow_button,
   output logic [1:0] song_confirm,
   output logic [1:0] state
);

   localparam int unsigned NB    = 3;
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned BTN_RED    = 0;
   localparam int unsigned BTN_BLUE   = 1;
   localparam int unsigned BTN_YELLOW = 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]       SONG_MAX = 2'(NUM_SONGS - 1);

   typedef enum logic [1:0] {
      ST_START  = 2'b00,
      ST_MENU   = 2'b01,
      ST_PLAY   = 2'b10,
      ST_FINISH = 2'b11
   } state_e;

   logic [NB-1:0]          btn_raw;
   logic [SYNC_STAGES-1:0] sync_q [NB];
   logic [SYNC_STAGES-1:0] sync_d [NB];
   logic [CNT_W-1:0]       cnt_q  [NB];
   logic [CNT_W-1:0]       cnt_d  [NB];
   logic [NB-1:0]          deb_q, deb_d;
   logic [NB-1:0]          deb_d1_q, deb_d1_d;
   logic [NB-1:0]          press_c;

   state_e     state_q, state_d;
   logic [1:0] song_q, song_d;

   assign btn_raw = {yellow_button, blue_button, red_button};

   // Button conditioning: sync chain, mismatch-count debounce, rising edge.
   always_comb begin
      for (int i = 0; i < NB; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
         cnt_d[i]  = '0;
         deb_d[i]  = deb_q[i];
         // Counter only advances while the synchronised level disagrees
         // with the debounced level; any agreeing cycle restarts it.
         if (sync_q[i][SYNC_STAGES-1] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = sync_q[i][SYNC_STAGES-1];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      deb_d1_d = deb_q;
      press_c  = deb_q & ~deb_d1_q;
   end

   // Next-state and song selection.
   always_comb begin
      state_d = state_q;
      song_d  = song_q;
      unique case (state_q)
         ST_START: begin
            if (press_c[BTN_RED]) state_d = ST_MENU;
         end
         ST_MENU: begin
            if (press_c[BTN_YELLOW]) begin
               state_d = ST_PLAY;
            end else if (press_c[BTN_RED]) begin
               song_d = (song_q == 2'd0) ? SONG_MAX : song_q - 2'd1;
            end else if (press_c[BTN_BLUE]) begin
               song_d = (song_q == SONG_MAX) ? 2'd0 : song_q + 2'd1;
            end
         end
         ST_PLAY: begin
            if (finish) begin
               state_d = ST_FINISH;
            end else if (press_c[BTN_BLUE]) begin
               state_d = ST_MENU;
            end
         end
         ST_FINISH: begin
            if (press_c[BTN_YELLOW]) state_d = ST_MENU;
         end
         default: state_d = ST_START;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            sync_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         deb_q    <= '0;
         deb_d1_q <= '0;
         state_q  <= ST_START;
         song_q   <= 2'd0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            sync_q[i] <= sync_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         deb_q    <= deb_d;
         deb_d1_q <= deb_d1_d;
         state_q  <= state_d;
         song_q   <= song_d;
      end
   end

   assign state        = state_q;
   assign song_confirm = song_q;

endmodule

// File: tb/tb_state_button.sv
// tb_state_button: scoreboard bench for state_button (default parameters).
// The driver applies inputs, advances a behavioural model at each rising
// edge and queues the expected {state, song}; a monitor pops and compares
// on each falling edge.
module tb_state_button;

   localparam int NS = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       finish;
   logic       red_button, blue_button, yellow_button;
   logic [1:0] song_confirm;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int exp_q[$];

   // Model: state/song as plain ints, raw-sample history per button.
   int m_state, m_song;
   bit hist [3][5];

   always #5 clk = ~clk;

   state_button #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .NUM_SONGS(NS)) dut (
      .clk(clk), .rst(rst), .finish(finish),
      .red_button(red_button), .blue_button(blue_button), .yellow_button(yellow_button),
      .song_confirm(song_confirm), .state(state)
   );

   // With 2 sync stages and 1-cycle debounce, a press acts at the edge
   // three samples after the raw level is first seen high.
   function automatic void model_edge(input bit r, input bit b, input bit y,
                                      input bit f, input bit rs);
      bit raw [3];
      bit pr, pb, py;
      raw[0] = r; raw[1] = b; raw[2] = y;
      if (rs) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 5; j++) hist[i][j] = 1'b0;
         m_state = 0;
         m_song  = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 4; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = raw[i];
         end
         pr = hist[0][3] & ~hist[0][4];
         pb = hist[1][3] & ~hist[1][4];
         py = hist[2][3] & ~hist[2][4];
         case (m_state)
            0: if (pr) m_state = 1;
            1: begin
               if (py)      m_state = 2;
               else if (pr) m_song = (m_song + NS - 1) % NS;
               else if (pb) m_song = (m_song + 1) % NS;
            end
            2: begin
               if (f)       m_state = 3;
               else if (pb) m_state = 1;
            end
            default: if (py) m_state = 1;
         endcase
      end
      exp_q.push_back(m_state * 4 + m_song);
   endfunction

   task automatic step(input bit r, input bit b, input bit y, input bit f, input bit rs);
      red_button = r; blue_button = b; yellow_button = y; finish = f; rst = rs;
      @(posedge clk);
      model_edge(r, b, y, f, rs);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   // Press = high for `hi` cycles then low for 5 cycles.
   task automatic press(input bit r, input bit b, input bit y, input int hi);
      for (int i = 0; i < hi; i++) step(r, b, y, 0, 0);
      idle(5);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() > 0) begin
         int e;
         logic [3:0] ev;
         e  = exp_q.pop_front();
         ev = 4'(e);
         checks++;
         if ({state, song_confirm} !== ev) begin
            errors++;
            $display("FAIL state_song cyc=%0d got state=%b song=%b exp state=%b song=%b",
                     cyc, state, song_confirm, ev[3:2], ev[1:0]);
         end
      end
   end

   initial begin
      bit lvl [3];
      int hold [3];
      bit fl;
      red_button = 0; blue_button = 0; yellow_button = 0; finish = 0; rst = 1;

      // Reset then idle
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      idle(20);
      // Red held: START -> MENU once
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
      idle(10);
      // Yellow held: MENU -> PLAY, then finish held -> FINISH
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
      idle(5);
      for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 0);
      idle(5);
      // Single-period yellow: FINISH -> MENU
      step(0, 0, 1, 0, 0);
      idle(6);
      // Song selection with wrap
      press(0, 1, 0, 2);
      press(0, 1, 0, 2);
      press(0, 1, 0, 2);
      press(1, 0, 0, 1);
      press(0, 0, 1, 3);
      press(1, 0, 0, 2);
      press(0, 0, 1, 2);
      // finish and blue press on the same edge in PLAY
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      idle(4);
      press(0, 0, 1, 1);
      // Red and yellow together in MENU
      press(1, 0, 1, 2);
      // Blue abort from PLAY, re-enter PLAY, then reset mid-PLAY
      press(0, 1, 0, 1);
      press(0, 0, 1, 1);
      step(0, 0, 0, 0, 1);
      idle(5);
      // Low-wrap: red from song 0
      press(1, 0, 0, 1);
      press(1, 0, 0, 1);

      // Randomised button levels with random hold times
      for (int i = 0; i < 3; i++) begin lvl[i] = 0; hold[i] = 1; end
      fl = 0;
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < 3; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               lvl[i]  = ($urandom_range(0, 99) < 35);
               hold[i] = $urandom_range(1, 9);
            end
         end
         if ($urandom_range(0, 99) < 8) fl = ~fl;
         step(lvl[0], lvl[1], lvl[2], fl, ($urandom_range(0, 599) == 0));
      end
      idle(3);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
